ganancia: RTL and testbench

- SPI programmer for the dual-channel programmable pre-amplifier (LTC6912-class) ahead of the audio ADC.
- On each rising edge of `clockenable`, shifts one 8-bit gain word, MSB first, to the amplifier.
- Drives the amplifier chip select and holds the amplifier out of shutdown.
- Write-only master; it never reads back from the amplifier.

---
 rtl/ganancia.sv | 126 ++++++++++++
 tb/tb_ganancia.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ganancia.sv
// SPI write-only programmer for an LTC6912-class dual-channel pre-amplifier.
// Each rising edge of clockenable, accepted while idle, shifts {GAIN_B, GAIN_A} MSB first.
module ganancia #(
  parameter logic [3:0] GAIN_A  = 4'b0001,
  parameter logic [3:0] GAIN_B  = 4'b0001,
  parameter int         CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clockenable,
  output logic mosi,
  output logic sck,
  output logic ampcs,
  output logic ampshdn
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    word, word_n;
  logic [2:0]    bit_idx, bit_n;
  logic          hist;
  logic          sck_n, mosi_n, ampcs_n;
  logic          last, start;

  assign last = (cnt == LAST);
  // The final edge of GAP counts as idle, so a new word can begin exactly 18 phases after t0.
  assign start = clockenable & ~hist & ((state == IDLE) | ((state == GAP) & last));

  always_comb begin
    state_n = state;
    cnt_n   = (state == IDLE) ? '0 : cnt + CW'(1);
    word_n  = word;
    bit_n   = bit_idx;
    sck_n   = sck;
    mosi_n  = mosi;
    ampcs_n = ampcs;
    case (state)
      IDLE: ;
      SHIFT_LO: begin
        if (last) begin
          state_n = SHIFT_HI;
          sck_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      SHIFT_HI: begin
        if (last) begin
          sck_n = 1'b0;
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = HOLD;
          end else begin
            state_n = SHIFT_LO;
            bit_n   = bit_idx + 3'd1;
            mosi_n  = word[6];
            word_n  = {word[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (last) begin
          state_n = GAP;
          ampcs_n = 1'b1;
          mosi_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (start) begin
      state_n = SHIFT_LO;
      cnt_n   = '0;
      word_n  = {GAIN_B, GAIN_A};
      bit_n   = 3'd0;
      sck_n   = 1'b0;
      mosi_n  = GAIN_B[3];
      ampcs_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      word    <= '0;
      bit_idx <= 3'd0;
      hist    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      ampcs   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      word    <= word_n;
      bit_idx <= bit_n;
      hist    <= clockenable;
      sck     <= sck_n;
      mosi    <= mosi_n;
      ampcs   <= ampcs_n;
    end
  end

  // The amplifier is never put into shutdown.
  assign ampshdn = 1'b0;

endmodule

// File: tb/tb_ganancia.sv
// Bench for ganancia: three parameterisations share clock, reset and clockenable and are
// compared every cycle against a timing model written in terms of offsets from the start edge.
module tb_ganancia;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clockenable = 1'b0;
  logic mosi_o[3];
  logic sck_o[3];
  logic ampcs_o[3];
  logic ampshdn_o[3];

  always #5 clock = ~clock;

  ganancia u_a (
    .clock(clock), .reset(reset), .clockenable(clockenable),
    .mosi(mosi_o[0]), .sck(sck_o[0]), .ampcs(ampcs_o[0]), .ampshdn(ampshdn_o[0])
  );
  ganancia #(.GAIN_A(4'h5), .GAIN_B(4'hA)) u_b (
    .clock(clock), .reset(reset), .clockenable(clockenable),
    .mosi(mosi_o[1]), .sck(sck_o[1]), .ampcs(ampcs_o[1]), .ampshdn(ampshdn_o[1])
  );
  ganancia #(.CLK_DIV(1)) u_c (
    .clock(clock), .reset(reset), .clockenable(clockenable),
    .mosi(mosi_o[2]), .sck(sck_o[2]), .ampcs(ampcs_o[2]), .ampshdn(ampshdn_o[2])
  );

  int total = 0;
  int bad = 0;

  int         div_c[3]  = '{4, 4, 1};
  logic [7:0] word_c[3] = '{8'h11, 8'hA5, 8'h11};

  // reference model: a transfer is fully described by its start edge number
  bit   busy[3];
  int   t0[3];
  int   cycle = 0;
  logic prev_ce = 1'b0;
  bit   armed = 1'b0;

  // monitor state built from sampled outputs
  logic [7:0] cap[3];
  logic [7:0] last_cap[3];
  int         low_run[3];
  int         last_low[3];
  int         falls[3];
  logic       prev_sck[3];
  logic       prev_cs[3];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  task automatic push_exp(input int i, input logic [7:0] w);
    case (i)
      0: exp_q0.push_back(w);
      1: exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  task automatic drop_exp(input int i);
    case (i)
      0: if (exp_q0.size() > 0) void'(exp_q0.pop_back());
      1: if (exp_q1.size() > 0) void'(exp_q1.pop_back());
      default: if (exp_q2.size() > 0) void'(exp_q2.pop_back());
    endcase
  endtask

  function automatic logic [7:0] pop_exp(input int i);
    logic [7:0] w;
    w = 'x;
    case (i)
      0: if (exp_q0.size() > 0) w = exp_q0.pop_front();
      1: if (exp_q1.size() > 0) w = exp_q1.pop_front();
      default: if (exp_q2.size() > 0) w = exp_q2.pop_front();
    endcase
    return w;
  endfunction

  function automatic int pending(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  // {ampshdn, ampcs, sck, mosi} expected after the most recent edge
  function automatic logic [3:0] expect_out(input int i);
    int o;
    int d;
    logic c;
    logic s;
    logic m;
    c = 1'b1;
    s = 1'b0;
    m = 1'b0;
    d = div_c[i];
    if (busy[i]) begin
      o = cycle - t0[i];
      if (o < 17 * d) c = 1'b0;
      if (o < 16 * d) begin
        s = ((o / d) % 2) == 1;
        m = word_c[i][7 - o / (2 * d)];
      end else if (o < 17 * d) begin
        m = word_c[i][0];
      end
    end
    return {1'b0, c, s, m};
  endfunction

  task automatic model(input logic r, input logic ce);
    cycle++;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        if (busy[i] && (cycle - t0[i]) < 17 * div_c[i]) drop_exp(i);
        busy[i] = 1'b0;
      end else begin
        if (busy[i] && (cycle - t0[i]) == 18 * div_c[i]) busy[i] = 1'b0;
        if (!busy[i] && ce && !prev_ce) begin
          busy[i] = 1'b1;
          t0[i]   = cycle;
          push_exp(i, word_c[i]);
        end
      end
    end
    prev_ce = r ? 1'b0 : ce;
    if (r) armed = 1'b1;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [3:0] got;
    logic [3:0] exp;
    logic [7:0] w;
    for (int i = 0; i < 3; i++) begin
      got = {ampshdn_o[i], ampcs_o[i], sck_o[i], mosi_o[i]};
      exp = expect_out(i);
      total++;
      assert (got === exp) else begin
        bad++;
        $error("FAIL pins[%0d] cycle=%0d observed=%b expected=%b (shdn,cs,sck,mosi)", i, cycle, got, exp);
      end
      if (sck_o[i] && !prev_sck[i]) cap[i] = {cap[i][6:0], mosi_o[i]};
      if (!ampcs_o[i] && prev_cs[i]) begin
        falls[i]++;
        low_run[i] = 0;
        cap[i] = 8'h00;
      end
      if (!ampcs_o[i]) low_run[i]++;
      if (ampcs_o[i] && !prev_cs[i]) begin
        last_low[i] = low_run[i];
        last_cap[i] = cap[i];
        if (low_run[i] == 17 * div_c[i]) begin
          w = pop_exp(i);
          total++;
          assert (cap[i] === w) else begin
            bad++;
            $error("FAIL word[%0d] observed=%h expected=%h", i, cap[i], w);
          end
        end
      end
      prev_sck[i] = sck_o[i];
      prev_cs[i]  = ampcs_o[i];
    end
  endtask

  task automatic step(input logic r, input logic ce);
    @(negedge clock);
    if (armed) check_cycle();
    reset = r;
    clockenable = ce;
    model(r, ce);
  endtask

  task automatic clear_falls();
    for (int i = 0; i < 3; i++) falls[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0; t0[i] = 0; cap[i] = 8'h00; last_cap[i] = 8'h00;
      low_run[i] = 0; last_low[i] = 0; falls[i] = 0;
      prev_sck[i] = 1'b0; prev_cs[i] = 1'b1;
    end

    // reset, then clockenable high on the first cycle out of reset
    repeat (3) step(1'b1, 1'b0);
    repeat (90) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    check_int("reset_first_low_a", last_low[0], 68);
    check_int("reset_first_low_c", last_low[2], 17);
    check_int("word_a", int'(last_cap[0]), 8'h11);
    check_int("word_b", int'(last_cap[1]), 8'hA5);
    check_int("word_c", int'(last_cap[2]), 8'h11);
    check_int("first_falls_a", falls[0], 1);
    check_int("first_falls_c", falls[2], 1);

    // level held high for 500 cycles gives one transfer
    repeat (20) step(1'b0, 1'b0);
    clear_falls();
    repeat (500) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    check_int("hold_falls_a", falls[0], 1);
    check_int("hold_falls_b", falls[1], 1);
    check_int("hold_falls_c", falls[2], 1);

    // clockenable toggling every 10 cycles
    for (int k = 0; k < 300; k++) step(1'b0, ((k / 10) % 2) == 1);
    repeat (80) step(1'b0, 1'b0);

    // reset during bit 3 of the D=4 instances
    step(1'b0, 1'b1);
    repeat (26) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_int("midreset_cs", int'(ampcs_o[0]), 1);
    check_int("midreset_sck", int'(sck_o[0]), 0);
    check_int("midreset_mosi", int'(mosi_o[0]), 0);
    repeat (5) step(1'b0, 1'b0);
    repeat (80) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_int("after_reset_low_a", last_low[0], 68);
    check_int("after_reset_word_a", int'(last_cap[0]), 8'h11);

    // a second edge exactly 18 cycles after t0 restarts the D=1 instance only
    repeat (80) step(1'b0, 1'b0);
    clear_falls();
    step(1'b0, 1'b1);
    repeat (17) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (80) step(1'b0, 1'b0);
    check_int("b2b_falls_a", falls[0], 1);
    check_int("b2b_falls_c", falls[2], 2);
    check_int("b2b_low_c", last_low[2], 17);

    // random clockenable activity with occasional resets
    begin
      logic ce;
      ce = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        if ($urandom_range(0, 7) == 0) ce = ~ce;
        step($urandom_range(0, 199) == 0, ce);
      end
    end
    repeat (100) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) check_int($sformatf("pending[%0d]", i), pending(i), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
